// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control blocks.
package riscv_pipe_pkg;

  // Hazard controller states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Default register index width (32 architectural registers).
  localparam int DEFAULT_REG_ADDR_W = 5;

  // Index of the hard-wired zero register x0.
  localparam int X0_IDX = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / stall controller: load-use bubbles, branch flushes,
// data-memory freeze with a wait watchdog, and saturating event counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs2,
  input  logic                  idex_MemRead,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  exmem_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;

  // Load in EX whose destination (not x0) feeds the instruction in ID.
  assign load_use = idex_MemRead
                  && (idex_rd != REG_ADDR_W'(X0_IDX))
                  && ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Control outputs, next state and counter increments, all from state and inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          stall_inc  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (exmem_branch_taken) begin
          {ifid_flush, idex_flush, exmem_flush} = 3'b111;
          flush_inc = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end
      end

      MEM_WAIT: begin
        // Branch and load-use are held off; they are re-evaluated back in RUN.
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          stall_inc = 1'b1;
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d = ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end

      ERR: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        stall_inc = 1'b1;
      end

      default: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Pipeline held completely still while reset is asserted.
    if (!reset) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      {ifid_flush, idex_flush, exmem_flush}           = 3'b000;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  // State and watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign err_timeout = (state_q == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// compared cycle by cycle against a behavioural model of the control rules.
module tb_hazard_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  // Output vector order: pc, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f
  localparam logic [6:0] C_DEF    = 7'b1111_000;
  localparam logic [6:0] C_FREEZE = 7'b0000_000;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_BR     = 7'b1111_111;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
  logic          ifid_uses_rs2, idex_MemRead, exmem_branch_taken, mem_req, mem_ready;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_flush, exmem_flush, err_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Model: frozen cycles of the current memory access, dead after timeout.
  int m_frozen = 0;
  bit m_dead   = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .MAX_MEM_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .ifid_rs1           (ifid_rs1),
    .ifid_rs2           (ifid_rs2),
    .ifid_uses_rs2      (ifid_uses_rs2),
    .idex_MemRead       (idex_MemRead),
    .idex_rd            (idex_rd),
    .exmem_branch_taken (exmem_branch_taken),
    .mem_req            (mem_req),
    .mem_ready          (mem_ready),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .idex_write         (idex_write),
    .exmem_write        (exmem_write),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
    .err_timeout        (err_timeout),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v + 1 > SAT) ? SAT : v + 1;
  endfunction

  // One clock cycle: drive inputs mid-cycle, check outputs, advance the model after the edge.
  task automatic cycle(input string tag, input logic rst,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic rq, input logic rdy);
    logic [6:0] exp_ctrl;
    bit lu, freeze_now, br_flush, lu_stall;
    reset = rst; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = u2;
    idex_MemRead = mr; idex_rd = rd; exmem_branch_taken = br;
    mem_req = rq; mem_ready = rdy;
    #1;
    freeze_now = 1'b0; br_flush = 1'b0; lu_stall = 1'b0;
    if (!rst) begin
      m_frozen = 0; m_dead = 1'b0; m_stall = 0; m_flush = 0;
      exp_ctrl = C_FREEZE;
    end else begin
      lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
      freeze_now = m_dead || ((m_frozen > 0) && !rdy) || ((m_frozen == 0) && rq && !rdy);
      br_flush   = !freeze_now && (m_frozen == 0) && br;
      lu_stall   = !freeze_now && (m_frozen == 0) && !br && lu;
      exp_ctrl   = freeze_now ? C_FREEZE : br_flush ? C_BR : lu_stall ? C_LU : C_DEF;
    end
    check({tag, ".ctrl"},
          {25'd0, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, exmem_flush},
          {25'd0, exp_ctrl});
    check({tag, ".err"}, {31'd0, err_timeout}, {31'd0, m_dead});
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, m_stall);
    check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, m_flush);
    @(posedge clk);
    #1;
    if (rst) begin
      if (freeze_now || lu_stall) m_stall = sat_inc(m_stall);
      if (br_flush) m_flush = sat_inc(m_flush);
      if (!m_dead) begin
        if (freeze_now) begin
          m_frozen++;
          if (m_frozen == MAXW + 1) m_dead = 1'b1;
        end else begin
          m_frozen = 0;
        end
      end
    end
  endtask

  task automatic idle(input string tag, input logic rdy);
    cycle(tag, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset(input string tag);
    cycle(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; ifid_rs1 = '0; ifid_rs2 = '0; ifid_uses_rs2 = 1'b0;
    idex_MemRead = 1'b0; idex_rd = '0; exmem_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset values.
    do_reset("rst0");
    do_reset("rst1");
    idle("idle0", 1'b0);

    // Load-use on rs2, then same load with rd = x0.
    cycle("lu_rs2", 1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lu_x0",  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs1", 1'b1, 5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cycle("lu_nou2",1'b1, 5'd1, 5'd4, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    check("lu_stall_total", {28'd0, stall_cnt}, 32'd2);

    // Branch flush wins over a load-use match.
    cycle("br_lu", 1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle("br_after", 1'b0);
    check("br_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    check("br_stall_cnt", {28'd0, stall_cnt}, 32'd2);

    // Memory wait of three cycles, released in the ready cycle.
    do_reset("mw_rst");
    for (int i = 0; i < 3; i++) cycle($sformatf("mw_wait%0d", i), 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
    cycle("mw_ready", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle("mw_after", 1'b0);
    check("mw_stall_cnt", {28'd0, stall_cnt}, 32'd3);
    cycle("mw_req_rdy", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Watchdog timeout and sticky error.
    do_reset("to_rst");
    for (int i = 0; i < MAXW + 1; i++) cycle($sformatf("to_wait%0d", i), 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle($sformatf("to_err%0d", i), 1'b1);
    check("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    do_reset("to_clear");
    idle("to_run", 1'b0);

    // Stall counter saturation.
    do_reset("sat_rst");
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i), 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    idle("sat_after", 1'b0);
    check("sat_value", {28'd0, stall_cnt}, 32'd15);

    // Reset asserted between edges in the middle of a memory wait.
    do_reset("ar_rst");
    cycle("ar_w0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle("ar_w1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle("ar_hit", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle("ar_run", 1'b0);

    // Random traffic with small register indices to provoke matches.
    for (int i = 0; i < 400; i++) begin
      cycle($sformatf("rnd%0d", i),
            ($urandom_range(0, 39) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
